// File: rtl/enet_rcr_staged_pkg.sv
// enet_pkg: shared constants, FSM encoding and mask helpers for the staged ENET RCR/ECR block.
package enet_pkg;

    localparam int RCR_DRT    = 1;
    localparam int RCR_PROM   = 3;
    localparam int RCR_BC_REJ = 4;
    localparam int RCR_FCE    = 5;
    localparam int RCR_PADEN  = 12;
    localparam int RCR_PAUFWD = 13;
    localparam int RCR_CRCFWD = 14;
    localparam int RCR_CFEN   = 15;
    localparam int RCR_MAX_FL = 16;
    localparam int RCR_NLC    = 30;

    localparam int ECR_RESET    = 0;
    localparam int ECR_ETHER_EN = 1;
    localparam int ECR_MII_SEL  = 3;

    localparam int ENET_RST_MAX_FL = 1518;

    localparam logic [31:0] ECR_FIELDS = (32'd1 << ECR_ETHER_EN) | (32'd1 << ECR_MII_SEL);

    typedef enum logic {
        ENET_RX_IDLE  = 1'b0,
        ENET_RX_FRAME = 1'b1
    } enet_rx_state_e;

    // Storable RCR bits; everything else reads back as zero.
    function automatic logic [31:0] rcr_mask(input int max_fl_w);
        logic [31:0] m;
        m = '0;
        m[RCR_DRT]    = 1'b1;
        m[RCR_PROM]   = 1'b1;
        m[RCR_BC_REJ] = 1'b1;
        m[RCR_FCE]    = 1'b1;
        m[RCR_PADEN]  = 1'b1;
        m[RCR_PAUFWD] = 1'b1;
        m[RCR_CRCFWD] = 1'b1;
        m[RCR_CFEN]   = 1'b1;
        for (int i = 0; i < max_fl_w; i++) m[RCR_MAX_FL + i] = 1'b1;
        m[RCR_NLC]    = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/enet_rcr_staged_if.sv
// enet_rcr_staged_if: register-decoder / receive-MAC side signals of the staged RCR/ECR block.
//   master: drives register writes and frame pulses, observes configuration and status.
//   slave : the register block itself.
interface enet_rcr_staged_if #(
    parameter int MAX_FL_W = 14
);
    logic                rcr_wen;
    logic                ecr_wen;
    logic [3:0]          reg_wstrb;
    logic [31:0]         reg_wdata;
    logic                rx_sof;
    logic                rx_eof;
    logic                ether_en, drt, mii_select, nlc, cfen, crcfwd, paufwd, paden, fce, bc_rej, prom;
    logic [MAX_FL_W-1:0] max_fl;
    logic [31:0]         rcr_rdata;
    logic [31:0]         ecr_rdata;
    logic                cfg_pending;
    logic                cfg_commit;
    logic                rx_busy;
    logic                rx_timeout;

    modport master (
        output rcr_wen, ecr_wen, reg_wstrb, reg_wdata, rx_sof, rx_eof,
        input  ether_en, drt, mii_select, nlc, cfen, crcfwd, paufwd, paden, fce, bc_rej, prom,
        input  max_fl, rcr_rdata, ecr_rdata, cfg_pending, cfg_commit, rx_busy, rx_timeout
    );

    modport slave (
        input  rcr_wen, ecr_wen, reg_wstrb, reg_wdata, rx_sof, rx_eof,
        output ether_en, drt, mii_select, nlc, cfen, crcfwd, paufwd, paden, fce, bc_rej, prom,
        output max_fl, rcr_rdata, ecr_rdata, cfg_pending, cfg_commit, rx_busy, rx_timeout
    );
endinterface

// File: rtl/enet_rcr_staged_cfg_shadow_reg.sv
// enet_cfg_shadow_reg: software-visible shadow register paired with a datapath-visible active copy.
//   clk, rst_n       clock, async active-low reset (both copies load RST)
//   wen_i, wdata_i   shadow load
//   commit_i         active <= shadow
//   clr_i            synchronous restore of RST into both copies, wins over everything
//   act_clr_i        bits forced low in the active copy at this edge, applied after any commit
//   shadow_o         shadow copy
//   active_o         active copy
module enet_cfg_shadow_reg #(
    parameter int           W   = 32,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wen_i,
    input  logic [W-1:0] wdata_i,
    input  logic         commit_i,
    input  logic         clr_i,
    input  logic [W-1:0] act_clr_i,
    output logic [W-1:0] shadow_o,
    output logic [W-1:0] active_o
);
    logic [W-1:0] shadow_q, shadow_d, active_q, active_d;

    always_comb begin
        shadow_d = clr_i ? RST : (wen_i ? wdata_i : shadow_q);
        active_d = clr_i ? RST : ((commit_i ? shadow_q : active_q) & ~act_clr_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RST;
            active_q <= RST;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign shadow_o = shadow_q;
    assign active_o = active_q;
endmodule

// File: rtl/enet_rcr_staged.sv
// enet_rcr_staged: staged RCR/ECR configuration registers for the ENET receive MAC (rx_clk domain).
//   rx_clk, rst_n  receive clock, async active-low reset
//   bus (slave)    register writes with byte strobes, shadow readback, rx_sof/rx_eof pulses,
//                  active configuration bits, max_fl, cfg_pending, cfg_commit, rx_busy, rx_timeout
// Writes land in the shadow copy; the active copy is refreshed only while no frame is in
// flight, so the receive path never sees configuration change mid-frame.
module enet_rcr_staged
    import enet_pkg::*;
#(
    parameter int MAX_FL_W   = 14,
    parameter int RST_MAX_FL = ENET_RST_MAX_FL,
    parameter int TIMEOUT_W  = 16
) (
    input logic              rx_clk,
    input logic              rst_n,
    enet_rcr_staged_if.slave bus
);
    localparam logic [31:0]          RCR_MASK = rcr_mask(MAX_FL_W);
    localparam logic [31:0]          RCR_RST  = (32'(RST_MAX_FL) << RCR_MAX_FL) & RCR_MASK;
    localparam logic [31:0]          ECR_EN   = 32'd1 << ECR_ETHER_EN;
    localparam logic [TIMEOUT_W-1:0] CNT_ALL  = '1;

    enet_rx_state_e       state_q;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_inc;
    logic                 pending_q, commit_q, timeout_q;
    logic [31:0]          strb_m, rcr_wdata, ecr_wdata, rcr_sh, rcr_act, ecr_sh, ecr_act;
    logic                 wr_rcr, wr_ecr, byte0_ecr, soft_rst, kill, commit;
    logic                 unused;

    assign strb_m    = strb_mask(bus.reg_wstrb);
    assign wr_rcr    = bus.rcr_wen && (bus.reg_wstrb != 4'h0);
    assign wr_ecr    = bus.ecr_wen && (bus.reg_wstrb != 4'h0);
    assign byte0_ecr = bus.ecr_wen && bus.reg_wstrb[0];
    assign soft_rst  = byte0_ecr && bus.reg_wdata[ECR_RESET];
    // Clearing ether_en bypasses staging so the MAC can be stopped mid-frame.
    assign kill      = byte0_ecr && !bus.reg_wdata[ECR_ETHER_EN];
    assign commit    = (state_q == ENET_RX_IDLE) && pending_q;
    assign cnt_inc   = cnt_q + TIMEOUT_W'(1);
    assign rcr_wdata = ((rcr_sh & ~strb_m) | (bus.reg_wdata & strb_m)) & RCR_MASK;
    assign ecr_wdata = ((ecr_sh & ~strb_m) | (bus.reg_wdata & strb_m)) & ECR_FIELDS;

    enet_cfg_shadow_reg #(.W(32), .RST(RCR_RST)) u_rcr (
        .clk       (rx_clk),
        .rst_n     (rst_n),
        .wen_i     (wr_rcr),
        .wdata_i   (rcr_wdata),
        .commit_i  (commit),
        .clr_i     (soft_rst),
        .act_clr_i ('0),
        .shadow_o  (rcr_sh),
        .active_o  (rcr_act)
    );

    enet_cfg_shadow_reg #(.W(32), .RST('0)) u_ecr (
        .clk       (rx_clk),
        .rst_n     (rst_n),
        .wen_i     (wr_ecr),
        .wdata_i   (ecr_wdata),
        .commit_i  (commit),
        .clr_i     (soft_rst),
        .act_clr_i (kill ? ECR_EN : 32'd0),
        .shadow_o  (ecr_sh),
        .active_o  (ecr_act)
    );

    // Frame tracker, watchdog and commit bookkeeping. A new write in the commit cycle keeps
    // pending set so it is committed on a later idle edge.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ENET_RX_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else if (soft_rst) begin
            state_q   <= ENET_RX_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            commit_q  <= commit;
            pending_q <= wr_rcr || wr_ecr || (pending_q && !commit);
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            if (state_q == ENET_RX_IDLE) begin
                if (bus.rx_sof) state_q <= ENET_RX_FRAME;
            end else if (!bus.rx_sof) begin
                if (bus.rx_eof) begin
                    state_q <= ENET_RX_IDLE;
                end else if (cnt_inc == CNT_ALL) begin
                    state_q   <= ENET_RX_IDLE;
                    timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign bus.drt         = rcr_act[RCR_DRT];
    assign bus.prom        = rcr_act[RCR_PROM];
    assign bus.bc_rej      = rcr_act[RCR_BC_REJ];
    assign bus.fce         = rcr_act[RCR_FCE];
    assign bus.paden       = rcr_act[RCR_PADEN];
    assign bus.paufwd      = rcr_act[RCR_PAUFWD];
    assign bus.crcfwd      = rcr_act[RCR_CRCFWD];
    assign bus.cfen        = rcr_act[RCR_CFEN];
    assign bus.max_fl      = rcr_act[RCR_MAX_FL +: MAX_FL_W];
    assign bus.nlc         = rcr_act[RCR_NLC];
    assign bus.ether_en    = ecr_act[ECR_ETHER_EN];
    assign bus.mii_select  = ecr_act[ECR_MII_SEL];
    assign bus.rcr_rdata   = rcr_sh;
    assign bus.ecr_rdata   = ecr_sh;
    assign bus.cfg_pending = pending_q;
    assign bus.cfg_commit  = commit_q;
    assign bus.rx_busy     = state_q == ENET_RX_FRAME;
    assign bus.rx_timeout  = timeout_q;

    // Unmapped storage bits are constant zero and intentionally never read.
    assign unused = ^{rcr_act, ecr_act};
endmodule

// File: tb/tb_enet_rcr_staged.sv
// tb_enet_rcr_staged: directed scenarios plus randomized traffic against a frame-level reference model.
module tb_enet_rcr_staged;
    localparam int          MFW     = 14;
    localparam logic [31:0] RCR_RST = 32'h05EE_0000;
    localparam logic [31:0] RCR_MSK = 32'h7FFF_F03A;
    localparam logic [31:0] ECR_MSK = 32'h0000_000A;
    localparam int          TO_CYC  = 15;

    logic rx_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always #5 rx_clk = ~rx_clk;

    enet_rcr_staged_if #(.MAX_FL_W(MFW)) bus ();

    enet_rcr_staged #(.MAX_FL_W(MFW), .RST_MAX_FL(1518), .TIMEOUT_W(4)) dut (
        .rx_clk (rx_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    logic [10:0] flags;
    logic [3:0]  stat;
    assign flags = {bus.ether_en, bus.drt, bus.mii_select, bus.nlc, bus.cfen, bus.crcfwd,
                    bus.paufwd, bus.paden, bus.fce, bus.bc_rej, bus.prom};
    assign stat  = {bus.cfg_pending, bus.cfg_commit, bus.rx_busy, bus.rx_timeout};

    logic [31:0] m_rcr, m_ecr, a_rcr, a_ecr;
    bit          m_busy, m_pend, e_commit, e_timeout;
    int          m_cyc;

    task automatic drive(input bit rw, input bit ew, input bit [3:0] s, input bit [31:0] d,
                         input bit sof, input bit eof);
        bus.rcr_wen = rw; bus.ecr_wen = ew; bus.reg_wstrb = s; bus.reg_wdata = d;
        bus.rx_sof = sof; bus.rx_eof = eof;
        @(posedge rx_clk); #1;
        bus.rcr_wen = 0; bus.ecr_wen = 0; bus.reg_wstrb = 0; bus.reg_wdata = 0;
        bus.rx_sof = 0; bus.rx_eof = 0;
    endtask

    task automatic model_reset();
        m_rcr = RCR_RST; m_ecr = 0; a_rcr = RCR_RST; a_ecr = 0;
        m_busy = 0; m_pend = 0; e_commit = 0; e_timeout = 0; m_cyc = 0;
    endtask

    // One clock edge of the register block, described field/byte-wise and by frame length.
    task automatic model_edge(input bit rw, input bit ew, input bit [3:0] s, input bit [31:0] d,
                              input bit sof, input bit eof);
        bit          do_commit;
        logic [31:0] nr, ne;
        do_commit = !m_busy && m_pend;
        if (ew && s[0] && d[0]) begin
            model_reset();
            return;
        end
        nr = m_rcr; ne = m_ecr;
        for (int b = 0; b < 4; b++) if (s[b]) begin
            if (rw) nr[8*b +: 8] = d[8*b +: 8];
            if (ew) ne[8*b +: 8] = d[8*b +: 8];
        end
        if (do_commit) begin a_rcr = m_rcr; a_ecr = m_ecr; end
        if (ew && s[0] && !d[1]) a_ecr[1] = 1'b0;
        m_rcr = nr & RCR_MSK; m_ecr = ne & ECR_MSK;
        m_pend = ((rw || ew) && s != 0) || (m_pend && !do_commit);
        e_commit = do_commit; e_timeout = 0;
        if (!m_busy) begin
            if (sof) begin m_busy = 1; m_cyc = 0; end
        end else if (sof) m_cyc = 0;
        else if (eof) m_busy = 0;
        else begin
            m_cyc++;
            if (m_cyc == TO_CYC) begin m_busy = 0; e_timeout = 1; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge rx_clk);
        @(negedge rx_clk); rst_n = 1;
        @(posedge rx_clk); #1;
        n_cmp++; if (bus.max_fl !== 14'd1518) begin n_err++; $display("FAIL reset max_fl got %0d exp 1518", bus.max_fl); end
        n_cmp++; if (bus.rcr_rdata !== RCR_RST) begin n_err++; $display("FAIL reset rcr_rdata got %h exp %h", bus.rcr_rdata, RCR_RST); end
        n_cmp++; if (bus.ecr_rdata !== 32'h0) begin n_err++; $display("FAIL reset ecr_rdata got %h exp 0", bus.ecr_rdata); end
        n_cmp++; if (flags !== 11'h0) begin n_err++; $display("FAIL reset flags got %h exp 0", flags); end
        n_cmp++; if (stat !== 4'h0) begin n_err++; $display("FAIL reset status got %b exp 0000", stat); end
    endtask

    task automatic test_idle_write();
        drive(1, 0, 4'hF, 32'h4000_F03A, 0, 0);
        n_cmp++; if (bus.rcr_rdata !== 32'h4000_F03A) begin n_err++; $display("FAIL idle_wr rdata got %h exp 4000f03a", bus.rcr_rdata); end
        n_cmp++; if (stat !== 4'b1000) begin n_err++; $display("FAIL idle_wr pending got %b exp 1000", stat); end
        n_cmp++; if (flags !== 11'h0) begin n_err++; $display("FAIL idle_wr staged flags got %h exp 0", flags); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b0100) begin n_err++; $display("FAIL idle_wr commit got %b exp 0100", stat); end
        n_cmp++; if (flags !== 11'h2FF) begin n_err++; $display("FAIL idle_wr flags got %h exp 2ff", flags); end
        n_cmp++; if (bus.max_fl !== 14'd0) begin n_err++; $display("FAIL idle_wr max_fl got %0d exp 0", bus.max_fl); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b0000) begin n_err++; $display("FAIL idle_wr commit_pulse got %b exp 0000", stat); end
    endtask

    task automatic test_midframe();
        drive(1, 0, 4'hF, 32'h0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (flags !== 11'h0) begin n_err++; $display("FAIL mid clear flags got %h exp 0", flags); end
        drive(0, 0, 0, 0, 1, 0);
        drive(1, 0, 4'hF, 32'h8, 0, 0);
        n_cmp++; if (stat !== 4'b1010) begin n_err++; $display("FAIL mid write status got %b exp 1010", stat); end
        repeat (2) begin
            drive(0, 0, 0, 0, 0, 0);
            n_cmp++; if (bus.prom !== 1'b0 || stat !== 4'b1010) begin n_err++; $display("FAIL mid hold prom=%b status=%b exp 0/1010", bus.prom, stat); end
        end
        drive(0, 0, 0, 0, 0, 1);
        n_cmp++; if (bus.prom !== 1'b0 || stat !== 4'b1000) begin n_err++; $display("FAIL mid eof prom=%b status=%b exp 0/1000", bus.prom, stat); end
        drive(0, 0, 0, 0, 1, 0);
        n_cmp++; if (bus.prom !== 1'b1 || stat !== 4'b0110) begin n_err++; $display("FAIL mid commit_sof prom=%b status=%b exp 1/0110", bus.prom, stat); end
        drive(0, 0, 0, 0, 0, 1);
        n_cmp++; if (stat !== 4'b0000) begin n_err++; $display("FAIL mid end status got %b exp 0000", stat); end
    endtask

    task automatic test_strobe();
        drive(1, 0, 4'hF, 32'h05EE_0000, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 4'h0, 32'hFFFF_FFFF, 0, 0);
        n_cmp++; if (bus.rcr_rdata !== 32'h05EE_0000 || stat !== 4'b0000) begin n_err++; $display("FAIL strb0 rdata=%h status=%b exp 05ee0000/0000", bus.rcr_rdata, stat); end
        drive(1, 0, 4'h1, 32'hFFFF_FFFF, 0, 0);
        n_cmp++; if (bus.rcr_rdata !== 32'h05EE_003A) begin n_err++; $display("FAIL strb1 rdata got %h exp 05ee003a", bus.rcr_rdata); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (flags !== 11'h207) begin n_err++; $display("FAIL strb1 flags got %h exp 207", flags); end
        n_cmp++; if (bus.max_fl !== 14'd1518) begin n_err++; $display("FAIL strb1 max_fl got %0d exp 1518", bus.max_fl); end
    endtask

    task automatic test_disable_soft_reset();
        drive(0, 1, 4'hF, 32'hA, 0, 0);
        n_cmp++; if (bus.ecr_rdata !== 32'hA) begin n_err++; $display("FAIL ecr rdata got %h exp a", bus.ecr_rdata); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (flags !== 11'h707) begin n_err++; $display("FAIL ecr commit flags got %h exp 707", flags); end
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 1, 4'h1, 32'h0, 0, 0);
        n_cmp++; if (flags !== 11'h307) begin n_err++; $display("FAIL disable flags got %h exp 307", flags); end
        n_cmp++; if (stat !== 4'b1010) begin n_err++; $display("FAIL disable status got %b exp 1010", stat); end
        drive(0, 1, 4'h1, 32'h1, 0, 0);
        n_cmp++; if (flags !== 11'h0 || bus.max_fl !== 14'd1518) begin n_err++; $display("FAIL softrst flags=%h max_fl=%0d exp 0/1518", flags, bus.max_fl); end
        n_cmp++; if (bus.rcr_rdata !== RCR_RST || bus.ecr_rdata !== 32'h0) begin n_err++; $display("FAIL softrst rdata rcr=%h ecr=%h exp %h/0", bus.rcr_rdata, bus.ecr_rdata, RCR_RST); end
        n_cmp++; if (stat !== 4'b0000) begin n_err++; $display("FAIL softrst status got %b exp 0000", stat); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b0000) begin n_err++; $display("FAIL softrst no_commit got %b exp 0000", stat); end
    endtask

    task automatic test_watchdog();
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 1; k < TO_CYC; k++) begin
            drive(k == 3, 0, (k == 3) ? 4'hF : 4'h0, 32'h8, 0, 0);
            n_cmp++; if (stat[1:0] !== 2'b10) begin n_err++; $display("FAIL wdog cycle %0d busy/timeout got %b exp 10", k, stat[1:0]); end
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b1001 || bus.prom !== 1'b0) begin n_err++; $display("FAIL wdog fire status=%b prom=%b exp 1001/0", stat, bus.prom); end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b0100 || bus.prom !== 1'b1) begin n_err++; $display("FAIL wdog commit status=%b prom=%b exp 0100/1", stat, bus.prom); end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 0, 0, 1, 0);
        repeat (9) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        n_cmp++; if (stat !== 4'b0010) begin n_err++; $display("FAIL b2b sof_eof status got %b exp 0010", stat); end
        for (int k = 1; k < TO_CYC; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            n_cmp++; if (stat !== 4'b0010) begin n_err++; $display("FAIL b2b restart cycle %0d status got %b exp 0010", k, stat); end
        end
        drive(0, 0, 0, 0, 0, 0);
        n_cmp++; if (stat !== 4'b0001) begin n_err++; $display("FAIL b2b timeout status got %b exp 0001", stat); end
        drive(0, 0, 0, 0, 0, 1);
        n_cmp++; if (stat !== 4'b0000) begin n_err++; $display("FAIL eof_idle status got %b exp 0000", stat); end
    endtask

    task automatic test_random();
        bit          rw, ew, sof, eof;
        bit [3:0]    s;
        bit [31:0]   d;
        logic [10:0] ef;
        drive(1, 0, 4'hF, 32'h4000_F03A, 0, 0);
        #2 rst_n = 0;
        #1;
        n_cmp++; if (bus.rcr_rdata !== RCR_RST || stat !== 4'b0000) begin n_err++; $display("FAIL async_rst rdata=%h status=%b exp %h/0000", bus.rcr_rdata, stat, RCR_RST); end
        @(negedge rx_clk); rst_n = 1;
        @(posedge rx_clk); #1;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            rw  = ($urandom_range(0, 4) == 0);
            ew  = ($urandom_range(0, 9) == 0);
            s   = 4'($urandom);
            d   = $urandom;
            if ($urandom_range(0, 7) != 0) d[0] = 1'b0;
            sof = ($urandom_range(0, 9) == 0);
            eof = ($urandom_range(0, 19) == 0);
            drive(rw, ew, s, d, sof, eof);
            model_edge(rw, ew, s, d, sof, eof);
            ef = {a_ecr[1], a_rcr[1], a_ecr[3], a_rcr[30], a_rcr[15], a_rcr[14], a_rcr[13], a_rcr[12], a_rcr[5], a_rcr[4], a_rcr[3]};
            n_cmp++; if (bus.rcr_rdata !== m_rcr) begin n_err++; $display("FAIL rand %0d rcr_rdata got %h exp %h", c, bus.rcr_rdata, m_rcr); end
            n_cmp++; if (bus.ecr_rdata !== m_ecr) begin n_err++; $display("FAIL rand %0d ecr_rdata got %h exp %h", c, bus.ecr_rdata, m_ecr); end
            n_cmp++; if (flags !== ef || bus.max_fl !== a_rcr[16 +: MFW]) begin n_err++; $display("FAIL rand %0d active flags=%h max_fl=%0d exp %h/%0d", c, flags, bus.max_fl, ef, a_rcr[16 +: MFW]); end
            n_cmp++; if (stat !== {m_pend, e_commit, m_busy, e_timeout}) begin n_err++; $display("FAIL rand %0d status got %b exp %b", c, stat, {m_pend, e_commit, m_busy, e_timeout}); end
        end
    endtask

    initial begin
        bus.rcr_wen = 0; bus.ecr_wen = 0; bus.reg_wstrb = 0; bus.reg_wdata = 0;
        bus.rx_sof = 0; bus.rx_eof = 0;
        test_reset();
        test_idle_write();
        test_midframe();
        test_strobe();
        test_disable_soft_reset();
        test_watchdog();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
